// File: rtl/nic_opl_multiport.sv
`timescale 1ns/1ps
// nic_opl_multiport: AXI4-Stream port forwarder with 2-entry skid output; define NIC_OPL_STATS_EN for packet counters
module nic_opl_multiport #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PHY_PORTS      = 4,
  parameter int SRC_PORT_POS       = 16,
  parameter int DST_PORT_POS       = 24
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic [1:0]                      cfg_mode,
  input  logic [2*NUM_PHY_PORTS-1:0]      cfg_default_dst,
  input  logic                            stats_clear,
  output logic [31:0]                     stat_pkt_in,
  output logic [31:0]                     stat_pkt_out,
  output logic [31:0]                     stat_pkt_drop
);
  localparam int PORT_W = 2*NUM_PHY_PORTS;
  localparam int KEEP_W = C_AXIS_DATA_WIDTH/8;
  localparam int ENT_W  = C_AXIS_DATA_WIDTH + KEEP_W + C_AXIS_TUSER_WIDTH + 1;
  typedef enum logic [1:0] {HEADER, FWD, DROP} state_t;
  state_t state_q, state_d;
  logic [PORT_W-1:0] dst_q, dst_d, src, nic_dst, hdr_dst, cur_dst;
  logic [1:0][ENT_W-1:0] mem_q, mem_d;
  logic [1:0] cnt_q, cnt_d;
  logic wp_q, wp_d, rp_q, rp_d, alive_q, alive_d;
  logic s_hs, m_hs, src_ok, push, drop_last;
  logic [C_AXIS_TUSER_WIDTH-1:0] user_mod;

  // Beat decode: validate the one-hot source and pick the destination for this beat
  always_comb begin
    src = s_axis_tuser[SRC_PORT_POS+:PORT_W];
    src_ok = $onehot(src);
    nic_dst = '0;
    for (int k = 0; k < NUM_PHY_PORTS; k++) begin
      nic_dst[2*k]   = src[2*k+1];
      nic_dst[2*k+1] = src[2*k];
    end
    hdr_dst = cfg_mode == 2'd1 ? src : cfg_mode == 2'd2 ? cfg_default_dst : nic_dst;
    cur_dst = state_q == HEADER ? hdr_dst : dst_q;
    user_mod = s_axis_tuser;
    user_mod[DST_PORT_POS+:PORT_W] = cur_dst;
    s_hs = s_axis_tvalid & s_axis_tready;
    m_hs = m_axis_tvalid & m_axis_tready;
    push = s_hs & (state_q == HEADER ? src_ok : state_q == FWD);
    drop_last = s_hs & s_axis_tlast & (state_q == HEADER ? ~src_ok : state_q == DROP);
  end

  // Next state: the header beat classifies the packet, an accepted tlast ends it
  always_comb begin
    state_d = state_q;
    if (s_hs)
      state_d = s_axis_tlast ? HEADER : state_q == HEADER ? (src_ok ? FWD : DROP) : state_q;
  end

  // State register
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) state_q <= HEADER;
    else state_q <= state_d;
  end

  // Skid buffer pointers/occupancy and the per-packet destination latch
  always_comb begin
    alive_d = 1'b1;
    dst_d = state_q == HEADER && s_hs ? hdr_dst : dst_q;
    mem_d = mem_q;
    if (push) mem_d[wp_q] = {s_axis_tdata, s_axis_tkeep, user_mod, s_axis_tlast};
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ m_hs;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, m_hs};
  end

  // Datapath registers; reset empties the buffer and holds off s_axis_tready
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      alive_q <= 1'b0;
      dst_q <= '0;
      mem_q <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      alive_q <= alive_d;
      dst_q <= dst_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs come straight from registers so tready never depends on m_axis_tready
  always_comb begin
    {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = mem_q[rp_q];
    m_axis_tvalid = cnt_q != 2'd0;
    s_axis_tready = alive_q & (cnt_q != 2'd2 | state_q == DROP);
  end

`ifdef NIC_OPL_STATS_EN
  logic [31:0] pkt_in_q, pkt_in_d, pkt_out_q, pkt_out_d, pkt_drop_q, pkt_drop_d;

  // Saturating packet counters; clear beats a simultaneous increment
  always_comb begin
    pkt_in_d   = stats_clear ? '0 : (s_hs & s_axis_tlast & ~&pkt_in_q) ? pkt_in_q + 32'd1 : pkt_in_q;
    pkt_out_d  = stats_clear ? '0 : (m_hs & m_axis_tlast & ~&pkt_out_q) ? pkt_out_q + 32'd1 : pkt_out_q;
    pkt_drop_d = stats_clear ? '0 : (drop_last & ~&pkt_drop_q) ? pkt_drop_q + 32'd1 : pkt_drop_q;
  end

  // Counter registers
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_in_q <= '0;
      pkt_out_q <= '0;
      pkt_drop_q <= '0;
    end else begin
      pkt_in_q <= pkt_in_d;
      pkt_out_q <= pkt_out_d;
      pkt_drop_q <= pkt_drop_d;
    end
  end

  assign stat_pkt_in = pkt_in_q;
  assign stat_pkt_out = pkt_out_q;
  assign stat_pkt_drop = pkt_drop_q;
`else
  logic unused_stats;
  assign unused_stats = stats_clear ^ drop_last;
  assign stat_pkt_in = '0;
  assign stat_pkt_out = '0;
  assign stat_pkt_drop = '0;
`endif
endmodule

// File: tb/tb_nic_opl_multiport.sv
`timescale 1ns/1ps
// tb_nic_opl_multiport: directed and randomized packets checked against a packet-level reference model
module tb_nic_opl_multiport;
  localparam int DW = 256, KW = 32, UW = 128, PW = 8, SP = 16, DP = 24;
`ifdef NIC_OPL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic axi_aclk = 1'b0, axi_reset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep = '0, m_axis_tkeep;
  logic [UW-1:0] s_axis_tuser = '0, m_axis_tuser;
  logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic [PW-1:0] cfg_default_dst = '0;
  logic stats_clear = 1'b0;
  logic [31:0] stat_pkt_in, stat_pkt_out, stat_pkt_drop;
  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic l;
  } beat_t;
  beat_t expq[$];
  int tests = 0, fails = 0;
  logic [31:0] exp_in = 0, exp_out = 0, exp_drop = 0;
  bit bp = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] held_d;
  logic [UW-1:0] held_u;

  always #5 axi_aclk = ~axi_aclk;

  nic_opl_multiport dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cfg_mode(cfg_mode), .cfg_default_dst(cfg_default_dst), .stats_clear(stats_clear),
    .stat_pkt_in(stat_pkt_in), .stat_pkt_out(stat_pkt_out), .stat_pkt_drop(stat_pkt_drop)
  );

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return v == 32'hFFFFFFFF ? v : v + 32'd1;
  endfunction

  function automatic logic [PW-1:0] exp_dst(input logic [PW-1:0] s, input logic [1:0] m, input logic [PW-1:0] d);
    int i = 0;
    if (m == 2'd1) return s;
    if (m == 2'd2) return d;
    for (int j = 0; j < PW; j++) if (s[j]) i = j;
    return PW'(1) << (i ^ 1);
  endfunction

  // Output monitor: compare every m-handshake with the model queue and check stall stability
  always @(negedge axi_aclk) begin
    beat_t b;
    if (!axi_reset && stall_prev) begin
      chk("hold_valid", m_axis_tvalid, 1'b1);
      chk("hold_data", m_axis_tdata, held_d);
      chk("hold_user", m_axis_tuser, held_u);
    end
    stall_prev = !axi_reset && m_axis_tvalid && !m_axis_tready;
    held_d = m_axis_tdata;
    held_u = m_axis_tuser;
    if (!axi_reset && m_axis_tvalid && m_axis_tready) begin
      if (expq.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
      else begin
        b = expq.pop_front();
        chk("out_data", m_axis_tdata, b.d);
        chk("out_keep", m_axis_tkeep, b.k);
        chk("out_user", m_axis_tuser, b.u);
        chk("out_last", m_axis_tlast, b.l);
        if (b.l) exp_out = sat_inc(exp_out);
      end
    end
  end

  task automatic tick();
    @(posedge axi_aclk);
    #1;
    m_axis_tready = bp ? ~m_axis_tready : 1'b1;
  endtask

  task automatic send_pkt(input logic [PW-1:0] src, input int n, input int mid_beat,
                          input logic [1:0] mid_mode, input int abort_after);
    logic [PW-1:0] dst;
    bit ok, acc;
    int t;
    beat_t b;
    ok = $onehot(src);
    dst = exp_dst(src, cfg_mode, cfg_default_dst);
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) break;
      if (i == mid_beat) begin
        cfg_mode = mid_mode;
        cfg_default_dst = PW'($urandom);
      end
      for (int w = 0; w < DW/32; w++) b.d[w*32+:32] = $urandom;
      for (int w = 0; w < UW/32; w++) b.u[w*32+:32] = $urandom;
      b.k = $urandom;
      b.u[SP+:PW] = src;
      b.l = (i == n-1);
      s_axis_tdata = b.d;
      s_axis_tkeep = b.k;
      s_axis_tuser = b.u;
      s_axis_tlast = b.l;
      s_axis_tvalid = 1'b1;
      t = 0;
      do begin
        @(negedge axi_aclk);
        acc = s_axis_tready;
        tick();
        t++;
      end while (!acc && t < 200);
      if (!acc) chk("s_ready_timeout", 1'b0, 1'b1);
      if (ok) begin
        b.u[DP+:PW] = dst;
        expq.push_back(b);
      end
      if (b.l) begin
        exp_in = sat_inc(exp_in);
        if (!ok) exp_drop = sat_inc(exp_drop);
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || m_axis_tvalid) && t < 500) begin
      tick();
      t++;
    end
    chk("drain_timeout", t < 500, 1'b1);
    tick();
    tick();
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_in"}, stat_pkt_in, STATS ? exp_in : 32'd0);
    chk({tag, "_out"}, stat_pkt_out, STATS ? exp_out : 32'd0);
    chk({tag, "_drop"}, stat_pkt_drop, STATS ? exp_drop : 32'd0);
  endtask

  initial begin
    logic [PW-1:0] src;
    repeat (3) tick();
    chk("rst_m_valid", m_axis_tvalid, 1'b0);
    chk("rst_s_ready", s_axis_tready, 1'b0);
    chk_stats("rst");
    axi_reset = 1'b0;
    tick();
    chk("ready_after_reset", s_axis_tready, 1'b1);
    cfg_mode = 2'd0;
    send_pkt(8'h04, 3, -1, 2'd0, -1);
    drain();
    chk_stats("nic_swap");
    send_pkt(8'h00, 2, -1, 2'd0, -1);
    send_pkt(8'h03, 2, -1, 2'd0, -1);
    drain();
    chk_stats("drop");
    bp = 1'b1;
    cfg_mode = 2'd1;
    send_pkt(8'h20, 10, -1, 2'd0, -1);
    drain();
    bp = 1'b0;
    chk_stats("backpressure");
    cfg_mode = 2'd2;
    cfg_default_dst = 8'h01;
    send_pkt(8'h40, 4, 1, 2'd0, -1);
    drain();
    chk_stats("mid_mode");
    for (int p = 0; p < 24; p++) begin
      bp = 1'($urandom);
      cfg_mode = 2'($urandom);
      cfg_default_dst = PW'($urandom);
      src = ($urandom_range(0, 3) != 0) ? PW'(1) << $urandom_range(0, 7) : PW'($urandom);
      send_pkt(src, $urandom_range(1, 6), -1, 2'd0, -1);
    end
    drain();
    bp = 1'b0;
    chk_stats("random");
    cfg_mode = 2'd0;
    send_pkt(8'h10, 5, -1, 2'd0, 2);
    axi_reset = 1'b1;
    #1;
    expq.delete();
    exp_in = 0;
    exp_out = 0;
    exp_drop = 0;
    chk("midrst_m_valid", m_axis_tvalid, 1'b0);
    chk("midrst_s_ready", s_axis_tready, 1'b0);
    chk_stats("midrst");
    tick();
    tick();
    axi_reset = 1'b0;
    tick();
    chk("ready_after_midrst", s_axis_tready, 1'b1);
    send_pkt(8'h01, 2, -1, 2'd0, -1);
    drain();
    chk_stats("after_midrst");
`ifdef NIC_OPL_STATS_EN
    force dut.pkt_in_q = 32'hFFFFFFFE;
    tick();
    release dut.pkt_in_q;
    exp_in = 32'hFFFFFFFE;
    for (int p = 0; p < 3; p++) send_pkt(8'h02, 1, -1, 2'd0, -1);
    drain();
    chk("sat_in", stat_pkt_in, 32'hFFFFFFFF);
    chk_stats("sat");
    stats_clear = 1'b1;
    send_pkt(8'h08, 1, -1, 2'd0, -1);
    drain();
    stats_clear = 1'b0;
    exp_in = 0;
    exp_out = 0;
    exp_drop = 0;
    tick();
    chk_stats("clear");
`endif
    chk("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
